// File: rtl/updown_seq_ctrl.sv
// Bounded up/down sequencer.
// A run bounces a counter between latched bounds lo and hi. It finishes after
// a programmed number of end-hits, or when aborted. All outputs are registered.
module updown_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             hold,
   input  logic             up_first,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [3:0]       laps,
   output logic [WIDTH-1:0] dout,
   output logic             dir,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] lo_q, hi_q, lo_nxt, hi_nxt;
   logic [WIDTH-1:0] dout_nxt, end_val;
   logic [3:0]       laps_q, laps_nxt, rev_cnt, rev_nxt;
   logic             dir_nxt, busy_nxt, done_nxt, err_nxt;
   logic             last_lap;

   // Move one count in the given direction. Callers guarantee no wrap.
   function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v,
                                                 input logic             up);
      step_val = up ? v + 1'b1 : v - 1'b1;
   endfunction

   // The value at which the current sweep turns round or finishes.
   always_comb begin
      end_val  = dir ? hi_q : lo_q;
      last_lap = (laps_q != 4'd0) && (rev_cnt == laps_q - 4'd1);
   end

   // Next-state and registered-output logic; priority abort > hold > end-hit/step.
   always_comb begin
      state_nxt = state;
      dout_nxt  = dout;
      dir_nxt   = dir;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      lo_nxt    = lo_q;
      hi_nxt    = hi_q;
      laps_nxt  = laps_q;
      rev_nxt   = rev_cnt;
      case (state)
         IDLE: begin
            busy_nxt = 1'b0;
            if (start && !abort) begin
               if (lo <= hi) begin
                  state_nxt = RUN;
                  busy_nxt  = 1'b1;
                  lo_nxt    = lo;
                  hi_nxt    = hi;
                  laps_nxt  = laps;
                  rev_nxt   = 4'd0;
                  dir_nxt   = up_first;
                  dout_nxt  = up_first ? lo : hi;
               end else begin
                  // A held bad start alternates err so it is never high twice running.
                  err_nxt = !err;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end else if (!hold) begin
               if (dout == end_val) begin
                  if (last_lap) begin
                     state_nxt = IDLE;
                     busy_nxt  = 1'b0;
                     done_nxt  = 1'b1;
                  end else begin
                     // Reverse without dwelling at the end value; a
                     // degenerate range just stays put.
                     dir_nxt = !dir;
                     rev_nxt = rev_cnt + 4'd1;
                     if (lo_q != hi_q)
                        dout_nxt = step_val(dout, !dir);
                  end
               end else begin
                  dout_nxt = step_val(dout, dir);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         dout    <= '0;
         dir     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         rev_cnt <= 4'd0;
         lo_q    <= '0;
         hi_q    <= '0;
         laps_q  <= 4'd0;
      end else begin
         state   <= state_nxt;
         dout    <= dout_nxt;
         dir     <= dir_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         err     <= err_nxt;
         rev_cnt <= rev_nxt;
         lo_q    <= lo_nxt;
         hi_q    <= hi_nxt;
         laps_q  <= laps_nxt;
      end
   end

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Self-checking bench for updown_seq_ctrl: directed scenarios plus random
// traffic, checked every cycle against a behavioural model of a run.
module tb_updown_seq_ctrl;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset, start, abort, hold, up_first;
   logic [WIDTH-1:0] lo, hi;
   logic [3:0]       laps;
   logic [WIDTH-1:0] dout;
   logic             dir, busy, done, err;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model of the sequencer.
   bit m_run, m_dir, m_done, m_err;
   int m_val, m_lo, m_hi, m_laps, m_hits;

   updown_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
      .up_first(up_first), .lo(lo), .hi(hi), .laps(laps),
      .dout(dout), .dir(dir), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      bit prev_err;
      prev_err = m_err;
      m_done   = 1'b0;
      m_err    = 1'b0;
      if (reset) begin
         m_run = 0; m_dir = 0; m_val = 0;
         m_lo = 0; m_hi = 0; m_laps = 0; m_hits = 0;
      end else if (!m_run) begin
         if (start && !abort) begin
            if (int'(lo) <= int'(hi)) begin
               m_run  = 1;
               m_lo   = int'(lo);
               m_hi   = int'(hi);
               m_laps = int'(laps);
               m_hits = 0;
               m_dir  = up_first;
               m_val  = up_first ? m_lo : m_hi;
            end else begin
               m_err = !prev_err;
            end
         end
      end else if (abort) begin
         m_run = 0;
      end else if (!hold) begin
         if (m_val == (m_dir ? m_hi : m_lo)) begin
            if (m_laps != 0 && m_hits == m_laps - 1) begin
               m_run  = 0;
               m_done = 1;
            end else begin
               m_dir  = !m_dir;
               m_hits = (m_hits + 1) % 16;
               if (m_lo != m_hi) m_val = m_val + (m_dir ? 1 : -1);
            end
         end else begin
            m_val = m_val + (m_dir ? 1 : -1);
         end
      end
   endtask

   // One clock: model update at the edge, compare outputs 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("dout", dout, m_val);
      chk("dir", dir, m_dir);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("done_err_excl", done & err, 0);
      if (busy) chk("in_range", (int'(dout) >= m_lo) && (int'(dout) <= m_hi), 1);
   endtask

   task automatic set_cfg(input int l, input int h, input bit u, input int n);
      lo = l[WIDTH-1:0]; hi = h[WIDTH-1:0]; up_first = u; laps = n[3:0];
   endtask

   initial begin
      int seq35[4];
      int seq36[10];
      logic [WIDTH-1:0] keep_dout;
      logic             keep_dir;
      seq35 = '{2, 3, 4, 5};
      seq36 = '{3, 2, 1, 0, 1, 2, 3, 2, 1, 0};

      reset = 1; start = 0; abort = 0; hold = 0;
      set_cfg(0, 0, 0, 0);
      tick(); tick();
      chk("rst_dout", dout, 0);
      chk("rst_busy", busy, 0);

      // Start accepted on the first edge after reset; simple up run, one lap.
      reset = 0;
      set_cfg(2, 5, 1, 1);
      start = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         start = 0;
         chk("seq35_dout", dout, seq35[i]);
      end
      tick();
      chk("seq35_done", done, 1);
      chk("seq35_busy", busy, 0);
      chk("seq35_hold_end", dout, 5);
      tick();
      chk("seq35_done_pulse", done, 0);

      // Down-first, three laps.
      set_cfg(0, 3, 0, 3);
      start = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         start = 0;
         chk("seq36_dout", dout, seq36[i]);
      end
      tick();
      chk("seq36_done", done, 1);
      chk("seq36_dout_end", dout, 0);

      // Endless run on a two-value range, then abort.
      set_cfg(14, 15, 1, 0);
      start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("seq37_nodone", done, 0);
      end
      keep_dout = dout;
      abort = 1;
      tick();
      abort = 0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_dout", dout, keep_dout);

      // Rejected start.
      keep_dout = dout;
      keep_dir  = dir;
      set_cfg(6, 2, 1, 1);
      start = 1;
      tick();
      start = 0;
      chk("bad_err", err, 1);
      chk("bad_busy", busy, 0);
      chk("bad_dout", dout, keep_dout);
      chk("bad_dir", dir, keep_dir);
      tick();
      chk("bad_err_pulse", err, 0);

      // Hold in mid-run and on the final end value.
      set_cfg(0, 7, 1, 1);
      start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 4; i++) tick();
      chk("hold_pre", dout, 4);
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_dout", dout, 4);
         chk("hold_busy", busy, 1);
      end
      hold = 0;
      for (int i = 5; i <= 7; i++) begin
         tick();
         chk("hold_resume", dout, i);
      end
      hold = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("hold_end_nodone", done, 0);
         chk("hold_end_busy", busy, 1);
      end
      hold = 0;
      tick();
      chk("hold_end_done", done, 1);

      // Reset mid-run, then abort blocking a start in IDLE.
      set_cfg(0, 7, 1, 0);
      start = 1;
      tick();
      start = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("mid_pre", dout, 5);
      reset = 1;
      tick();
      reset = 0;
      chk("mid_rst_dout", dout, 0);
      chk("mid_rst_dir", dir, 0);
      chk("mid_rst_busy", busy, 0);
      start = 1; abort = 1;
      tick();
      start = 0; abort = 0;
      chk("abort_blocks_start", busy, 0);

      // A reset pulse between edges must be ignored.
      set_cfg(1, 9, 1, 0);
      start = 1;
      tick();
      start = 0;
      tick();
      reset = 1;
      #2;
      reset = 0;
      tick();
      chk("glitch_busy", busy, 1);

      // Random traffic, including configuration changes during runs.
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 3) == 0);
         abort = ($urandom_range(0, 39) == 0);
         hold  = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 2) == 0) begin
            lo       = WIDTH'($urandom_range(0, 15));
            hi       = WIDTH'($urandom_range(0, 15));
            up_first = 1'($urandom_range(0, 1));
            laps     = 4'($urandom_range(0, 4));
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/updown_seq_ctrl.md
UPDOWN_SEQ_CTRL -- requirements
Module: updown_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, sets the counter width in bits.
REQ-002 clk  input  1  clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a run; accepted only in IDLE.
REQ-005 abort  input  1  terminate a run immediately, without done.
REQ-006 hold  input  1  freeze the run while high.
REQ-007 up_first  input  1  initial direction, sampled at start: 1 = up, 0 = down.
REQ-008 lo  input  WIDTH  lower bound, sampled at start.
REQ-009 hi  input  WIDTH  upper bound, sampled at start.
REQ-010 laps  input  4  number of end-hits before done, sampled at start; 0 = run until abort.
REQ-011 dout  output  WIDTH  current count value.
REQ-012 dir  output  1  current direction: 1 = up, 0 = down.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  single-cycle pulse on normal completion.
REQ-015 err  output  1  single-cycle pulse on a rejected start.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and RUN; all outputs SHALL be registered.
REQ-017 In IDLE, start=1, abort=0 and lo<=hi SHALL latch lo, hi, laps and up_first, clear rev_cnt, set dir=up_first, load dout=(up_first ? lo : hi), and enter RUN; busy SHALL be 1 from the next cycle.
REQ-018 In IDLE, start=1, abort=0 and lo>hi SHALL pulse err for one cycle and leave state, dout and dir unchanged.
REQ-019 The end value SHALL be hi when dir=1 and lo when dir=0; an end-hit is a RUN cycle with hold=0 and dout equal to the end value.
REQ-020 In a RUN cycle with hold=0 and no end-hit, dout SHALL step by +1 (dir=1) or -1 (dir=0).
REQ-021 On an end-hit with laps_latched!=0 and rev_cnt==laps_latched-1, the block SHALL:
- enter IDLE and pulse done for one cycle;
- drop busy in that same cycle;
- hold dout at the end value.
REQ-022 On any other end-hit, the block SHALL:
- invert dir;
- step dout one count in the new direction in the same cycle, with no dwell;
- increment rev_cnt (4-bit, wraps mod 16).
REQ-023 If lo==hi, each end-hit SHALL leave dout unchanged while still inverting dir and counting the hit.
REQ-024 In RUN, hold=1 SHALL freeze dout, dir and rev_cnt, keep busy=1, and suppress end-hit processing.
REQ-025 In RUN, abort=1 SHALL enter IDLE on the next edge with busy=0 and done=0, and SHALL hold dout and dir.
REQ-026 Priority SHALL be reset > abort > hold > end-hit/step.
REQ-027 abort in IDLE SHALL be ignored, and it SHALL block a same-cycle start.
REQ-028 start in RUN SHALL be ignored.
REQ-029 Changes on lo, hi, laps and up_first during RUN SHALL have no effect.
REQ-030 dout SHALL never leave [lo,hi] during RUN; no modular wrap SHALL occur.
REQ-031 done and err SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.

Reset
REQ-032 reset=1 at a posedge SHALL, regardless of state, force:
- state=IDLE;
- dout=0, dir=0, busy=0, done=0, err=0;
- rev_cnt=0 and all latched configuration=0.
REQ-033 Reset SHALL act only on posedge clk; a reset pulse between edges SHALL have no effect.
REQ-034 The first edge after reset deasserts SHALL accept start.

Verification
REQ-035 WIDTH=4, lo=2, hi=5, up_first=1, laps=1, one-cycle start -> dout 2,3,4,5 on successive cycles; next cycle done=1 and busy=0 with dout=5.
REQ-036 lo=0, hi=3, up_first=0, laps=3 -> dout 3,2,1,0,1,2,3,2,1,0; dir toggles at each end; next cycle done=1 with dout=0.
REQ-037 lo=14, hi=15, laps=0 -> dout alternates 14,15 for 40 cycles with no done; abort -> next cycle busy=0, done=0, dout holds.
REQ-038 start with lo=6, hi=2 -> err=1 for one cycle; busy, dout and dir unchanged.
REQ-039 lo=0, hi=7, up_first=1, laps=1, hold=1 for 3 cycles while dout=4 -> dout stays 4 and busy=1; after release dout continues 5,6,7 then done; also, hold=1 on the cycle dout=7 delays done until hold=0.
REQ-040 reset=1 mid-run at dout=5, dir=1 -> next edge dout=0, dir=0, busy=0, done=0; start=1 with abort=1 in IDLE -> no run begins.
